// File: rtl/trace_collector_pkg.sv
// Shared types for the trace collector: the trace record layout, its width and the
// serialiser state encoding.
package trace_collector_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  flags;
  } trace_output;

  localparam int unsigned TRACE_RECORD_WIDTH = $bits(trace_output);

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } collector_state_t;

  function automatic int unsigned words_for(input int unsigned rec_w, input int unsigned dw);
    return (rec_w + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with synchronous flush. DEPTH must be a power of two so the
// pointers wrap by natural overflow.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PtrW + 1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/trace_collector.sv
// Trace sink: buffers trace records in a FIFO and serialises each one, least-significant
// word first, onto a valid/ready drain stream. Records arriving while full are counted.
module trace_collector
  import trace_collector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned OVF_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     trace_data_ready,
  input  trace_output              trace_data_i,
  output logic                     drain_valid,
  output logic [DATA_WIDTH-1:0]    drain_data,
  output logic                     drain_last,
  input  logic                     drain_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [OVF_WIDTH-1:0]     overflow_count
);

  localparam int unsigned Words = words_for(TRACE_RECORD_WIDTH, DATA_WIDTH);
  localparam int unsigned PadW  = Words * DATA_WIDTH;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;

  collector_state_t                state_q, state_d;
  logic [PadW-1:0]                 shift_q, shift_d;
  logic [IdxW-1:0]                 idx_q, idx_d;
  logic [OVF_WIDTH-1:0]            ovf_q;
  logic [TRACE_RECORD_WIDTH-1:0]   fifo_rdata;
  logic                            fifo_full, fifo_empty;
  logic                            push, drop, pop, handshake, word_last;

  // Full is the registered count, so a same-cycle pop never makes room for a push.
  assign push      = trace_data_ready & enable & ~fifo_full & ~flush;
  assign drop      = trace_data_ready & enable & fifo_full & ~flush;
  assign handshake = (state_q == SEND) & drain_ready;
  assign word_last = (idx_q == IdxW'(Words - 1));
  assign pop       = ~flush & ~fifo_empty & ((state_q == IDLE) | (handshake & word_last));

  trace_fifo #(
    .WIDTH (TRACE_RECORD_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (trace_data_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (!fifo_empty) state_d = SEND;
        SEND:    if (handshake && word_last && fifo_empty) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    drain_valid = (state_q == SEND);
    drain_data  = drain_valid ? shift_q[DATA_WIDTH-1:0] : '0;
    drain_last  = drain_valid & word_last;
  end

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (pop) begin
      shift_d = PadW'(fifo_rdata);
      idx_d   = '0;
    end else if (!flush && handshake && !word_last) begin
      shift_d = shift_q >> DATA_WIDTH;
      idx_d   = idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
      ovf_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      if (drop && ovf_q != '1) ovf_q <= ovf_q + OVF_WIDTH'(1);
    end
  end

  assign overflow_count = ovf_q;

endmodule
